// File: rtl/run_detector.sv
// run_detector
//
// Streaming run-length detector. It scans each accepted WIDTH-bit word from
// the MSB (earliest bit) to the LSB (latest bit) and looks for a run of at
// least run_len consecutive bits equal to pol. The trailing run carries into
// the next accepted word, and it holds across idle cycles. All outputs are
// registered, so there is one cycle of latency.
//
// Ports
//   clk         : clock, rising edge
//   reset       : synchronous active-high reset (highest priority)
//   in_valid    : data/pol/run_len are accepted this cycle
//   data        : stream word, data[WIDTH-1] earliest, data[0] latest
//   pol         : 1 = runs of ones, 0 = runs of zeros
//   run_len     : required run length, 0 disables, clamped to MAXRUN
//   clear       : synchronous clear of status and run state (beats in_valid)
//   hit         : one-cycle pulse, previous accepted word contained a run
//   flag        : sticky hit indicator
//   run_count   : trailing run length carried forward, saturates at MAXRUN
//   match_count : number of hitting words, saturating
module run_detector #(
  parameter int WIDTH  = 8,
  parameter int MAXRUN = 16,
  parameter int CNT_W  = 16,
  parameter int RL_W   = $clog2(MAXRUN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] data,
  input  logic             pol,
  input  logic [RL_W-1:0]  run_len,
  input  logic             clear,
  output logic             hit,
  output logic             flag,
  output logic [RL_W-1:0]  run_count,
  output logic [CNT_W-1:0] match_count
);

  localparam logic [RL_W-1:0]  MAX_RL  = RL_W'(MAXRUN);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             hit_reg;
  logic             flag_reg;
  logic [RL_W-1:0]  run_count_reg;
  logic [CNT_W-1:0] match_count_reg;

  // Effective threshold after clamping to the tracker's saturation point.
  logic [RL_W-1:0] thr;
  assign thr = (run_len > MAX_RL) ? MAX_RL : run_len;

  // chain[k] is the run length after the first k bits of the word have been
  // consumed. Each stage either extends the run (saturating) or breaks it.
  logic [RL_W-1:0]  chain [0:WIDTH];
  logic [WIDTH-1:0] qual;
  logic             word_hit;

  assign chain[0] = run_count_reg;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_scan
      // Saturate before adding so MAXRUN+1 never has to fit in RL_W bits.
      assign chain[gi+1] = (data[WIDTH-1-gi] == pol)
                         ? ((chain[gi] >= MAX_RL) ? MAX_RL : chain[gi] + 1'b1)
                         : '0;
      assign qual[gi] = (chain[gi+1] >= thr);
    end
  endgenerate

  // With run_len = 0 the threshold is 0 and every stage would qualify, so
  // the word is gated off explicitly.
  assign word_hit = (run_len != '0) && (|qual);

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_reg         <= 1'b0;
      flag_reg        <= 1'b0;
      run_count_reg   <= '0;
      match_count_reg <= '0;
    end else if (clear) begin
      // Any word presented alongside clear is dropped.
      hit_reg         <= 1'b0;
      flag_reg        <= 1'b0;
      run_count_reg   <= '0;
      match_count_reg <= '0;
    end else if (in_valid) begin
      hit_reg       <= word_hit;
      run_count_reg <= chain[WIDTH];
      if (word_hit) begin
        flag_reg <= 1'b1;
        if (match_count_reg != CNT_MAX) begin
          match_count_reg <= match_count_reg + 1'b1;
        end
      end
    end else begin
      hit_reg <= 1'b0;
    end
  end

  assign hit         = hit_reg;
  assign flag        = flag_reg;
  assign run_count   = run_count_reg;
  assign match_count = match_count_reg;

endmodule

// File: tb/tb_run_detector.sv
module tb_run_detector;

  localparam int WIDTH  = 8;
  localparam int MAXRUN = 16;
  localparam int RL_W   = 5;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] data = '0;
  logic             pol = 1'b1;
  logic [RL_W-1:0]  run_len = '0;
  logic             clear = 1'b0;

  // Instance a: default 16-bit counter. Instance b: 2-bit counter.
  logic             hit_a, flag_a, hit_b, flag_b;
  logic [RL_W-1:0]  rc_a, rc_b;
  logic [15:0]      mc_a;
  logic [1:0]       mc_b;

  run_detector #(.WIDTH(WIDTH), .MAXRUN(MAXRUN), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .data(data), .pol(pol),
    .run_len(run_len), .clear(clear), .hit(hit_a), .flag(flag_a),
    .run_count(rc_a), .match_count(mc_a)
  );

  run_detector #(.WIDTH(WIDTH), .MAXRUN(MAXRUN), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .data(data), .pol(pol),
    .run_len(run_len), .clear(clear), .hit(hit_b), .flag(flag_b),
    .run_count(rc_b), .match_count(mc_b)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The word is treated as a time-ordered bit sequence; the model counts the
  // current run of matching bits with plain integers and an unbounded match
  // tally, saturating only when compared with each instance's counter.
  int m_run = 0;
  int m_tally = 0;
  bit m_hit = 0;
  bit m_flag = 0;

  always @(posedge clk) begin
    int r;
    int need;
    bit h;
    if (reset || clear) begin
      m_run   <= 0;
      m_tally <= 0;
      m_hit   <= 0;
      m_flag  <= 0;
    end else if (in_valid) begin
      r    = m_run;
      need = (int'(run_len) > MAXRUN) ? MAXRUN : int'(run_len);
      h    = 0;
      for (int t = 0; t < WIDTH; t++) begin
        if (data[WIDTH-1-t] == pol) r = (r + 1 > MAXRUN) ? MAXRUN : r + 1;
        else r = 0;
        if (need > 0 && r >= need) h = 1;
      end
      m_run <= r;
      m_hit <= h;
      if (h) begin
        m_flag  <= 1;
        m_tally <= m_tally + 1;
      end
    end else begin
      m_hit <= 0;
    end
  end

  // Cycle-by-cycle comparison on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model hit_a", int'(hit_a), int'(m_hit));
      chk("model flag_a", int'(flag_a), int'(m_flag));
      chk("model run_count_a", int'(rc_a), m_run);
      chk("model match_count_a", int'(mc_a), (m_tally > 65535) ? 65535 : m_tally);
      chk("model hit_b", int'(hit_b), int'(m_hit));
      chk("model flag_b", int'(flag_b), int'(m_flag));
      chk("model run_count_b", int'(rc_b), m_run);
      chk("model match_count_b", int'(mc_b), (m_tally > 3) ? 3 : m_tally);
    end
  end

  // ---------------- stimulus helpers ----------------
  // All helpers start and end 1 time unit after a rising edge.
  task automatic send(input logic [7:0] d, input logic p, input int rl);
    data = d; pol = p; run_len = RL_W'(rl); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    $display("word %b pol=%0d run_len=%0d -> hit=%0d flag=%0d run_count=%0d match_count=%0d/%0d",
             d, p, rl, hit_a, flag_a, rc_a, mc_a, mc_b);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic expect_a(input string name, input int h, input int f,
                          input int rc, input int mc);
    chk({name, " hit"}, int'(hit_a), h);
    chk({name, " flag"}, int'(flag_a), f);
    chk({name, " run_count"}, int'(rc_a), rc);
    chk({name, " match_count"}, int'(mc_a), mc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    chk_en = 1'b1;
    expect_a("reset", 0, 0, 0, 0);

    // Three-ones word.
    send(8'b1110_0000, 1'b1, 3);
    expect_a("e0", 1, 1, 0, 1);
    idle(1);
    chk("e0 next hit", int'(hit_a), 0);
    chk("e0 next flag", int'(flag_a), 1);

    // Cross-boundary run, back to back.
    do_clear();
    send(8'b0000_0011, 1'b1, 3);
    expect_a("xb1", 0, 0, 2, 0);
    send(8'b1000_0000, 1'b1, 3);
    expect_a("xb2", 1, 1, 0, 1);

    // Same with three idle cycles in between.
    do_clear();
    send(8'b0000_0011, 1'b1, 3);
    idle(3);
    chk("idle hold run_count", int'(rc_a), 2);
    chk("idle hit low", int'(hit_a), 0);
    send(8'b1000_0000, 1'b1, 3);
    expect_a("xb idle", 1, 1, 0, 1);

    // Run tracker saturation with run_len = 16.
    do_clear();
    send(8'hFF, 1'b1, 16);
    expect_a("sat1", 0, 0, 8, 0);
    send(8'hFF, 1'b1, 16);
    expect_a("sat2", 1, 1, 16, 1);
    send(8'hFF, 1'b1, 16);
    expect_a("sat3", 1, 1, 16, 2);

    // Build flag=1, match_count=5, run_count=2, then clear with a valid word.
    send(8'b1111_1011, 1'b1, 3);
    expect_a("build3", 1, 1, 2, 3);
    send(8'b1110_0011, 1'b1, 3);
    send(8'b1110_0011, 1'b1, 3);
    expect_a("build5", 1, 1, 2, 5);
    chk("build5 match_count_b", int'(mc_b), 3);
    data = 8'hFF; in_valid = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; clear = 1'b0;
    expect_a("clear wins", 0, 0, 0, 0);
    chk("clear wins match_count_b", int'(mc_b), 0);

    // Zero polarity, then disabled detection.
    send(8'b1000_0111, 1'b0, 4);
    expect_a("pol0", 1, 1, 0, 1);
    send(8'h00, 1'b0, 0);
    expect_a("disabled", 0, 1, 8, 1);

    // Polarity flip keeps the carried run length.
    do_clear();
    send(8'b0000_0011, 1'b1, 3);
    send(8'b0111_1111, 1'b0, 3);
    expect_a("pol flip", 1, 1, 0, 1);

    // run_len above MAXRUN is clamped.
    do_clear();
    send(8'hFF, 1'b1, 20);
    expect_a("clamp1", 0, 0, 8, 0);
    send(8'hFF, 1'b1, 20);
    expect_a("clamp2", 1, 1, 16, 1);

    // Counter saturation on the 2-bit instance.
    do_clear();
    for (int k = 0; k < 5; k++) begin
      send(8'b1110_0000, 1'b1, 3);
      chk($sformatf("cnt2 hit %0d", k), int'(hit_b), 1);
      chk($sformatf("cnt2 match_count %0d", k), int'(mc_b), (k + 1 > 3) ? 3 : k + 1);
    end
    chk("cnt16 after five", int'(mc_a), 5);

    // Reset mid-stream drops the carried run.
    send(8'b0000_0011, 1'b1, 3);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    expect_a("mid reset", 0, 0, 0, 0);
    send(8'b1000_0000, 1'b1, 3);
    expect_a("after reset", 0, 0, 0, 0);

    idle(2);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
